seq_multiplier: RTL

Iterative shift-add unsigned multiplier that sits directly upstream of the 18-bit load-enabled result register. It takes two 9-bit operands on a `start` strobe and computes their exact 18-bit product over WIDTH cycles. It then presents the product together with a one-cycle `done` pulse, and `done` is wired straight to the downstream register's `ld`.

---
 rtl/mult_pkg.sv | 14 +
 rtl/seq_mult_ctrl.sv | 53 +++++
 rtl/seq_multiplier.sv | 65 ++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 9;
    localparam int PROD_WIDTH = 2 * MULT_WIDTH;
    localparam int CNT_WIDTH  = $clog2(MULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the shift-add multiplier: FSM and iteration counter.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load,
    output logic shift,
    output logic finish,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                cnt <= '0;
            else if (shift)
                cnt <= cnt + 1'b1;
        end
    end

    assign load   = (state == IDLE) && start;
    assign shift  = (state == CALC);
    assign finish = shift && (cnt == LAST);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier; done pulses with a fresh product.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic             load;
    logic             shift;
    logic             finish;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    seq_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .load   (load),
        .shift  (shift),
        .finish (finish),
        .busy   (busy),
        .done   (done)
    );

    // Carry lands in sum[WIDTH] and shifts into the top of the accumulator.
    assign addend = mplier[0] ? {1'b0, mcand} : '0;
    assign sum    = {1'b0, acc_hi} + addend;
    assign hi_nxt = sum[WIDTH:1];
    assign lo_nxt = {sum[0], mplier[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc_hi <= '0;
        end else if (shift) begin
            acc_hi <= hi_nxt;
            mplier <= lo_nxt;
            if (finish)
                product <= {hi_nxt, lo_nxt};
        end
    end

endmodule
